// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port count, port indices, arbiter states.
package noc_pkg;

   localparam int N_PORTS    = 5;

   localparam int PORT_LOCAL = 0;
   localparam int PORT_N     = 1;
   localparam int PORT_E     = 2;
   localparam int PORT_S     = 3;
   localparam int PORT_W     = 4;

   typedef enum logic {
      IDLE,
      LOCKED
   } arb_state_t;

endpackage

// File: rtl/out_port_arbiter_rr_pick.sv
// Rotating-priority picker: first requester at or after ptr, cyclically.
module rr_pick #(
   parameter int N = noc_pkg::N_PORTS,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] win_oh,
   output logic [W-1:0] win_idx
);

   logic         found;
   logic [W-1:0] sel;

   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      found   = 1'b0;
      sel     = '0;
      for (int k = 0; k < N; k++) begin
         sel = W'((int'(ptr) + k) % N);
         if (!found && req[sel]) begin
            found       = 1'b1;
            win_oh[sel] = 1'b1;
            win_idx     = sel;
         end
      end
   end

endmodule

// File: rtl/out_port_arbiter.sv
// Round-robin output-port arbiter holding its grant from head to tail flit.
// Define ARB_WATCHDOG_EN to add a stall watchdog that force-releases the lock.
module out_port_arbiter #(
   parameter int N_PORTS     = noc_pkg::N_PORTS,
   parameter int WDOG_CYCLES = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_PORTS-1:0] req,
   input  logic [N_PORTS-1:0] valid,
   input  logic [N_PORTS-1:0] tail,
   input  logic               out_ready,
   output logic [N_PORTS-1:0] grant,
   output logic               grant_valid,
   output logic               xfer,
   output logic               wdog_err
);
   import noc_pkg::*;

   localparam int PTR_W = $clog2(N_PORTS);

   arb_state_t         state_q, state_d;
   logic [N_PORTS-1:0] grant_q, grant_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   win_q, win_d;
   logic               wdog_err_q, wdog_err_d;
   logic [N_PORTS-1:0] pick_oh;
   logic [PTR_W-1:0]   pick_idx;
   logic [PTR_W-1:0]   ptr_nxt;
   logic               tail_hit;
   logic               force_rel;

   rr_pick #(
      .N (N_PORTS),
      .W (PTR_W)
   ) u_pick (
      .req     (req),
      .ptr     (ptr_q),
      .win_oh  (pick_oh),
      .win_idx (pick_idx)
   );

   assign xfer     = |(grant_q & valid) & out_ready;
   assign tail_hit = xfer & |(grant_q & valid & tail);
   assign ptr_nxt  = (win_q == PTR_W'(N_PORTS - 1)) ? '0 : win_q + 1'b1;

`ifdef ARB_WATCHDOG_EN
   localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d     = cnt_q;
      force_rel = 1'b0;
      if (state_q != LOCKED || xfer) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(WDOG_CYCLES - 1)) begin
         force_rel = 1'b1;
         cnt_d     = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
`else
   assign force_rel = 1'b0;
`endif

   // Grant only changes on lock entry or release; LOCKED ignores req entirely.
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      win_d      = win_q;
      wdog_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            grant_d = '0;
            if (|req) begin
               grant_d = pick_oh;
               win_d   = pick_idx;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (tail_hit || force_rel) begin
               grant_d    = '0;
               state_d    = IDLE;
               ptr_d      = ptr_nxt;
               wdog_err_d = force_rel;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         ptr_q      <= '0;
         win_q      <= '0;
         wdog_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         win_q      <= win_d;
         wdog_err_q <= wdog_err_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign wdog_err    = wdog_err_q;

endmodule
